multdiv_unit: RTL and testbench

Responder for the execute stage's multiply/divide request. Execute presents operands, the operation type and a held `is_multdiv` request. This block runs the operation over several cycles and returns HI/LO with an `ok` indication. The hazard unit stalls execute while `is_multdiv && !ok`.

---
 rtl/execute_pkg.sv | 32 +++
 rtl/multdiv_unit_if.sv | 25 ++
 rtl/div_iter.sv | 23 ++
 rtl/multdiv_unit.sv | 133 +++++++++++++
 tb/tb_multdiv_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - execute stage shared types and helpers
package execute_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MULT_S = 2'd0,
        MULT_U = 2'd1,
        DIV_S  = 2'd2,
        DIV_U  = 2'd3
    } multicycle_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

    function automatic logic is_signed_op(input multicycle_type_t t);
        return (t == MULT_S) || (t == DIV_S);
    endfunction

    function automatic logic is_mult_op(input multicycle_type_t t);
        return (t == MULT_S) || (t == MULT_U);
    endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// rtl/multdiv_unit_if.sv - execute-to-multdiv request/response bundle
interface multdiv_unit_if;
    import execute_pkg::*;

    logic [31:0]      a;
    logic [31:0]      b;
    logic             is_multdiv;
    multicycle_type_t multicycle_type;
    logic             flush;
    logic             advance;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic             ok;

    modport master (
        output a, b, is_multdiv, multicycle_type, flush, advance,
        input  hi, lo, ok
    );

    modport slave (
        input  a, b, is_multdiv, multicycle_type, flush, advance,
        output hi, lo, ok
    );

endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - one combinational restoring divide step on a {remainder, quotient} pair
module div_iter (
    input  logic [63:0] pair,
    input  logic [31:0] divisor,
    output logic [63:0] pair_next
);

    logic [32:0] rem_shifted;
    logic [32:0] diff;

    // Remainder stays below the divisor, so the shifted value fits 33 bits and
    // the sign of the 33-bit difference is the trial-subtract outcome.
    always_comb begin
        rem_shifted = pair[63:31];
        diff        = rem_shifted - {1'b0, divisor};
        if (!diff[32]) begin
            pair_next = {diff[31:0], pair[30:0], 1'b1};
        end else begin
            pair_next = {pair[62:0], 1'b0};
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multi-cycle multiply/divide responder for the execute stage
module multdiv_unit
    import execute_pkg::*;
#(
    parameter int DIV_STEPS = 32
) (
    input  logic           clk,
    input  logic           resetn,
    multdiv_unit_if.slave  bus
);

    md_state_t        state_q, state_d;
    multicycle_type_t type_q, type_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [63:0]      rq_q, rq_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             ok_q, ok_d;

    logic [63:0]        rq_next;
    logic signed [32:0] ext_a, ext_b;
    logic signed [63:0] product;
    logic [31:0]        quo_fix, rem_fix;
    logic [31:0]        in_a, in_b;

    div_iter u_div_iter (
        .pair      (rq_q),
        .divisor   (opb_q),
        .pair_next (rq_next)
    );

    assign ext_a   = (type_q == MULT_S) ? {opa_q[31], opa_q} : {1'b0, opa_q};
    assign ext_b   = (type_q == MULT_S) ? {opb_q[31], opb_q} : {1'b0, opb_q};
    assign product = 64'(ext_a) * 64'(ext_b);

    // Divide runs on magnitudes; unsigned ops latch zero signs so no fix-up applies.
    assign quo_fix = (sa_q ^ sb_q) ? -rq_q[31:0]  : rq_q[31:0];
    assign rem_fix = sa_q          ? -rq_q[63:32] : rq_q[63:32];

    assign in_a = (bus.multicycle_type == DIV_S) ? magnitude(bus.a) : bus.a;
    assign in_b = (bus.multicycle_type == DIV_S) ? magnitude(bus.b) : bus.b;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        rq_d    = rq_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.is_multdiv) begin
                        type_d  = bus.multicycle_type;
                        opa_d   = in_a;
                        opb_d   = in_b;
                        sa_d    = is_signed_op(bus.multicycle_type) & bus.a[31];
                        sb_d    = is_signed_op(bus.multicycle_type) & bus.b[31];
                        rq_d    = {32'd0, in_a};
                        cnt_d   = 6'(DIV_STEPS);
                        state_d = is_mult_op(bus.multicycle_type) ? MUL : DIV;
                    end
                end
                MUL: begin
                    {hi_d, lo_d} = product;
                    state_d      = DONE;
                end
                DIV: begin
                    if (cnt_q != 6'd0) begin
                        rq_d  = rq_next;
                        cnt_d = cnt_q - 6'd1;
                    end else begin
                        lo_d    = quo_fix;
                        hi_d    = rem_fix;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.advance) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ok_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            type_q  <= MULT_S;
            cnt_q   <= 6'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            rq_q    <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            rq_q    <= rq_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ok_q    <= ok_d;
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
    assign bus.ok = ok_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - randomized self-checking bench for multdiv_unit
module tb_multdiv_unit;
    import execute_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    multdiv_unit_if bus ();

    multdiv_unit #(.DIV_STEPS(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference results straight from the arithmetic definition, {hi, lo}.
    function automatic logic [63:0] model(input multicycle_type_t t, input logic [31:0] x, input logic [31:0] y);
        longint n, d, q, r;
        logic [63:0] p;
        n = longint'($signed(x));
        d = longint'($signed(y));
        case (t)
            MULT_S: begin
                q = n * d;
                return q;
            end
            MULT_U: begin
                p = {32'd0, x} * {32'd0, y};
                return p;
            end
            DIV_U: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 0) return {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                q = n / d;
                r = n % d;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle at posedge+1; leaves the DUT in IDLE at posedge+1.
    task automatic run_op(input multicycle_type_t t, input logic [31:0] x, input logic [31:0] y,
                          input bit drop_req, input int hold);
        logic [63:0] exp;
        int lat;
        int want;
        exp  = model(t, x, y);
        want = is_mult_op(t) ? 2 : 34;
        bus.a = x;
        bus.b = y;
        bus.multicycle_type = t;
        bus.is_multdiv = 1'b1;
        bus.advance = 1'b0;
        bus.flush = 1'b0;
        #1;
        check_eq("ok_low_at_request", bus.ok, 0);
        lat = 0;
        do begin
            tick();
            lat++;
            bus.a = $urandom;
            bus.b = $urandom;
            if (drop_req) bus.is_multdiv = 1'b0;
        end while (!bus.ok && lat < 40);
        check_eq($sformatf("latency_%s", t.name()), lat, want);
        check_eq($sformatf("result_%s_%h_%h", t.name(), x, y), {bus.hi, bus.lo}, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("ok_held_stall", bus.ok, 1);
            check_eq("result_held_stall", {bus.hi, bus.lo}, exp);
        end
        bus.advance = 1'b1;
        tick();
        bus.advance = 1'b0;
        bus.is_multdiv = 1'b0;
        check_eq("ok_drop_after_advance", bus.ok, 0);
        check_eq("result_kept_idle", {bus.hi, bus.lo}, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] prev;
        logic [63:0] exp;
        multicycle_type_t t;

        bus.a = '0;
        bus.b = '0;
        bus.is_multdiv = 1'b0;
        bus.multicycle_type = MULT_S;
        bus.flush = 1'b0;
        bus.advance = 1'b0;
        repeat (3) tick();
        check_eq("reset_ok", bus.ok, 0);
        check_eq("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        resetn = 1'b1;
        tick();

        run_op(MULT_S, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
        check_eq("tp_mult_s", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(MULT_U, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);
        check_eq("tp_mult_u", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(DIV_S, 32'hFFFF_FFF9, 32'd2, 1'b0, 3);
        check_eq("tp_div_s", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(DIV_U, 32'h0000_1234, 32'd0, 1'b0, 0);
        check_eq("tp_divu_by_zero", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);
        run_op(DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check_eq("tp_div_s_overflow", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(DIV_S, 32'h8000_0000, 32'd0, 1'b0, 0);
        check_eq("tp_divs_neg_by_zero", {bus.hi, bus.lo}, 64'h8000_0000_0000_0001);
        run_op(DIV_S, 32'd5, 32'd0, 1'b0, 0);
        check_eq("tp_divs_pos_by_zero", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
        run_op(DIV_U, 32'd100, 32'd7, 1'b1, 1);
        check_eq("tp_drop_req", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

        // Flush at cycle 10 of a divide: no commit, back to IDLE.
        prev = {bus.hi, bus.lo};
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'd3;
        bus.multicycle_type = DIV_U;
        bus.is_multdiv = 1'b1;
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.is_multdiv = 1'b0;
        check_eq("flush_ok", bus.ok, 0);
        check_eq("flush_hilo_kept", {bus.hi, bus.lo}, prev);
        repeat (40) tick();
        check_eq("flush_no_late_ok", bus.ok, 0);
        check_eq("flush_no_late_commit", {bus.hi, bus.lo}, prev);
        run_op(MULT_U, 32'h0001_0000, 32'h0003_0000, 1'b0, 0);

        // flush together with advance in DONE: flush wins, result already committed.
        exp = model(MULT_S, 32'h7FFF_FFFF, 32'h8000_0000);
        bus.a = 32'h7FFF_FFFF;
        bus.b = 32'h8000_0000;
        bus.multicycle_type = MULT_S;
        bus.is_multdiv = 1'b1;
        tick();
        tick();
        check_eq("flush_adv_ok_before", bus.ok, 1);
        bus.flush = 1'b1;
        bus.advance = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.advance = 1'b0;
        bus.is_multdiv = 1'b0;
        check_eq("flush_adv_ok", bus.ok, 0);
        check_eq("flush_adv_hilo", {bus.hi, bus.lo}, exp);

        // Asynchronous reset in cycle 1 of a multiply.
        bus.a = 32'h1234_5678;
        bus.b = 32'h9ABC_DEF0;
        bus.multicycle_type = MULT_U;
        bus.is_multdiv = 1'b1;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_reset_ok", bus.ok, 0);
        check_eq("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        bus.is_multdiv = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        check_eq("post_reset_idle_ok", bus.ok, 0);
        check_eq("post_reset_idle_hilo", {bus.hi, bus.lo}, 64'd0);

        for (int i = 0; i < 36; i++) begin
            t = multicycle_type_t'($urandom_range(0, 3));
            run_op(t, pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
